tlp_router: RTL and testbench
=============================

TLP_ROUTER -- requirements
Module: tlp_router

Interface
REQ-001 SHALL have parameter DATA_W, default 12, giving the word width shared with the upstream FIFO.
REQ-002 SHALL have parameter NUM_DEST, default 4, giving the number of destination queues, addressed by a 2-bit route field.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (one clock; reset low asserts immediately, release is synchronous to clk).
REQ-005 SHALL have port state, input, 4 bits: system state, one-hot; 4'b0001 = soft clear, 4'b0010 = init, 4'b0100 and 4'b1000 = active.
REQ-006 SHALL have port src_empty, input, 1 bit: the upstream FIFO holds no words.
REQ-007 SHALL have port src_data, input, DATA_W bits: the upstream FIFO output, valid the cycle after src_pop.
REQ-008 SHALL have port src_pop, output, 1 bit: the pop request to the upstream FIFO.
REQ-009 SHALL have port dst_almost_full, input, NUM_DEST bits: per-destination almost_full flags.
REQ-010 SHALL have port dst_push, output, NUM_DEST bits: per-destination push strobe, at most one bit high.
REQ-011 SHALL have port dst_data, output, DATA_W bits: the word presented to the destination queues.
REQ-012 SHALL have port stall, output, 1 bit: high while a held word waits on a full destination.
REQ-013 SHALL have port dst_count, output, 5*NUM_DEST bits: per-destination push counters, destination 0 in the LSBs.

Function
REQ-014 SHALL implement the FSM states IDLE, FETCH, WAIT, ROUTE and STALL.
REQ-015 SHALL move IDLE->FETCH when state is active and src_empty=0; otherwise stay in IDLE.
REQ-016 SHALL drive src_pop=1 for exactly one cycle in FETCH, then enter WAIT unconditionally.
REQ-017 SHALL, in WAIT, capture src_data into the hold register regardless of state, then enter ROUTE.
REQ-018 SHALL take the destination index from hold[DATA_W-1:DATA_W-2], i.e. bits [11:10].
REQ-019 SHALL, in ROUTE or STALL, when active and dst_almost_full[idx]=0:
  - assert dst_push[idx] for one cycle with dst_data=hold;
  - go to FETCH if src_empty=0, else go to IDLE.
REQ-020 SHALL, in ROUTE or STALL, when dst_almost_full[idx]=1 or state is not active, enter or remain in STALL, keep the held word, and push nothing.
REQ-021 SHALL drive stall=1 exactly while in STALL.
REQ-022 SHALL achieve a throughput of one word per 3 cycles with no backpressure, and a latency of 2 cycles from src_pop to dst_push.
REQ-023 SHALL hold dst_data at its last pushed value between pushes.
REQ-024 SHALL never pop while holding a word, so no word is lost or duplicated across stalls.
REQ-025 SHALL, for a src_empty change in the same cycle as a push decision, use the sampled value of that cycle.

Reset
REQ-026 SHALL, on reset low, set FSM=IDLE, src_pop=0, dst_push=0, dst_data=0, hold=0, stall=0 and dst_count=0.
REQ-027 SHALL treat state=4'b0001 at a clock edge as a synchronous clear with the same values as REQ-026.
REQ-028 SHALL discard any word in flight or held when reset occurs mid-operation, with no push.
REQ-029 SHALL keep the FSM frozen in state=4'b0010, except for the WAIT capture of REQ-017.

Configuration
REQ-030 SHALL, with macro TLP_ROUTER_STATS_EN defined, increment counter i by 1 on each dst_push[i], wrapping modulo 32 (31->0).
REQ-031 SHALL, without TLP_ROUTER_STATS_EN, keep the dst_count port present and tie it to 0, with no counter logic.

Structure
REQ-032 SHALL place the FSM state encoding, the route-field MSB/LSB positions, NUM_DEST and the one-hot state codes in shared package tlp_router_pkg.
REQ-033 SHALL implement the counters in one sub-module, tlp_router_stats, instantiated only under TLP_ROUTER_STATS_EN.

Verification
REQ-034 SHALL cover single word: state=4'b0100, src_empty 1->0 with next src_data=12'hC05 -> src_pop at T+1, dst_push=4'b1000 and dst_data=12'hC05 at T+3, then IDLE.
REQ-035 SHALL cover backpressure: word 12'h4AA with dst_almost_full=4'b0010 -> stall=1 and no push; clearing bit1 -> dst_push=4'b0010 next cycle, and no src_pop during the stall.
REQ-036 SHALL cover a burst: 4 words 12'h000, 12'h401, 12'h802, 12'hC03 -> one push to each destination in order, pushes 3 cycles apart, dst_count=20'h08421 with the macro.
REQ-037 SHALL cover reset mid-transfer: reset low during WAIT -> no push, all outputs 0; after release with src_empty=1 -> stays IDLE.
REQ-038 SHALL cover counter wrap: 33 pushes to destination 2 -> dst_count[14:10]=1; without the macro -> dst_count=0.
REQ-039 SHALL cover state gating: state=4'b0010 while src_empty=0 -> no src_pop; state 4'b0100 -> src_pop next cycle.

Source files
------------

// File: rtl/tlp_router_pkg.sv
// Shared constants and types for the TLP router.
// TLP_ROUTER_STATS_EN enables the per-destination push counters.
package tlp_router_pkg;

  localparam int DATA_W_DFLT   = 12;
  localparam int NUM_DEST_DFLT = 4;
  localparam int CNT_W         = 5;

  // Route field sits in the top two bits of the word.
  localparam int ROUTE_MSB_OFS = 1;
  localparam int ROUTE_LSB_OFS = 2;

  localparam logic [3:0] ST_CLEAR = 4'b0001;
  localparam logic [3:0] ST_INIT  = 4'b0010;
  localparam logic [3:0] ST_ACT0  = 4'b0100;
  localparam logic [3:0] ST_ACT1  = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_ROUTE,
    S_STALL
  } fsm_t;

  function automatic logic is_active(
    input logic [3:0] st
  );
    return (st == ST_ACT0) || (st == ST_ACT1);
  endfunction

endpackage

// File: rtl/tlp_router_stats.sv
// Per-destination push counters, 5 bits each, wrapping.
// Instantiated only when TLP_ROUTER_STATS_EN is defined.
module tlp_router_stats
  import tlp_router_pkg::*;
#(
  parameter int NUM_DEST = NUM_DEST_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_clear,
  input  logic [NUM_DEST-1:0]       i_push,
  output logic [CNT_W*NUM_DEST-1:0] o_count
);

  for (genvar g = 0; g < NUM_DEST; g++) begin : g_cnt
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_cnt <= '0;
      end else if (i_clear) begin
        r_cnt <= '0;
      end else if (i_push[g]) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign o_count[g*CNT_W +: CNT_W] = r_cnt;
  end

endmodule

// File: rtl/tlp_router.sv
// Pops words from an upstream FIFO and pushes each to the queue named by its top two bits.
// TLP_ROUTER_STATS_EN adds per-destination push counters on dst_count.
module tlp_router
  import tlp_router_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DFLT,
  parameter int NUM_DEST = NUM_DEST_DFLT
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [3:0]                state,
  input  logic                      src_empty,
  input  logic [DATA_W-1:0]         src_data,
  output logic                      src_pop,
  input  logic [NUM_DEST-1:0]       dst_almost_full,
  output logic [NUM_DEST-1:0]       dst_push,
  output logic [DATA_W-1:0]         dst_data,
  output logic                      stall,
  output logic [CNT_W*NUM_DEST-1:0] dst_count
);

  fsm_t                r_fsm;
  logic [DATA_W-1:0]   r_hold;
  logic [DATA_W-1:0]   r_last;
  logic                r_src_pop;
  logic                r_stall;

  logic                w_active;
  logic                w_init;
  logic                w_clear;
  logic                w_route;
  logic                w_full;
  logic                w_push;
  logic [1:0]          w_idx;
  logic [NUM_DEST-1:0] w_push_vec;

  assign w_active = is_active(state);
  assign w_init   = (state == ST_INIT);
  assign w_clear  = (state == ST_CLEAR);

  assign w_idx   = r_hold[DATA_W-ROUTE_MSB_OFS:DATA_W-ROUTE_LSB_OFS];
  assign w_full  = dst_almost_full[w_idx];
  assign w_route = (r_fsm == S_ROUTE) || (r_fsm == S_STALL);
  assign w_push  = w_route && w_active && !w_full;

  always_comb begin
    w_push_vec = '0;
    if (w_push) begin
      w_push_vec[w_idx] = 1'b1;
    end
  end

  // Push is decided in the ROUTE/STALL cycle itself to keep 3-cycle throughput.
  assign dst_push = w_push_vec;
  assign dst_data = w_push ? r_hold : r_last;
  assign src_pop  = r_src_pop;
  assign stall    = r_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm     <= S_IDLE;
      r_hold    <= '0;
      r_last    <= '0;
      r_src_pop <= 1'b0;
      r_stall   <= 1'b0;
    end else if (w_clear) begin
      r_fsm     <= S_IDLE;
      r_hold    <= '0;
      r_last    <= '0;
      r_src_pop <= 1'b0;
      r_stall   <= 1'b0;
    end else begin
      if (w_push) begin
        r_last <= r_hold;
      end
      unique case (r_fsm)
        S_IDLE: begin
          if (w_active && !src_empty) begin
            r_fsm     <= S_FETCH;
            r_src_pop <= 1'b1;
          end
        end
        S_FETCH: begin
          r_fsm     <= S_WAIT;
          r_src_pop <= 1'b0;
        end
        S_WAIT: begin
          r_hold <= src_data;
          r_fsm  <= S_ROUTE;
        end
        S_ROUTE, S_STALL: begin
          if (w_push) begin
            r_stall <= 1'b0;
            if (!src_empty) begin
              r_fsm     <= S_FETCH;
              r_src_pop <= 1'b1;
            end else begin
              r_fsm <= S_IDLE;
            end
          end else if (!w_init) begin
            // Init freezes a held word in place; other inactive codes stall.
            r_fsm   <= S_STALL;
            r_stall <= 1'b1;
          end
        end
        default: begin
          r_fsm     <= S_IDLE;
          r_src_pop <= 1'b0;
          r_stall   <= 1'b0;
        end
      endcase
    end
  end

`ifdef TLP_ROUTER_STATS_EN
  tlp_router_stats #(
    .NUM_DEST (NUM_DEST)
  ) u_stats (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_clear),
    .i_push  (w_push_vec),
    .o_count (dst_count)
  );
`else
  assign dst_count = '0;
`endif

endmodule

// File: tb/tb_tlp_router.sv
// Directed self-checking bench for tlp_router.
// Expected counter values depend on TLP_ROUTER_STATS_EN.
module tb_tlp_router;

  localparam int DW = 12;
  localparam int ND = 4;

  logic          clk;
  logic          reset;
  logic [3:0]    state;
  logic          src_empty;
  logic [DW-1:0] src_data;
  logic          src_pop;
  logic [ND-1:0] dst_almost_full;
  logic [ND-1:0] dst_push;
  logic [DW-1:0] dst_data;
  logic          stall;
  logic [19:0]   dst_count;

  int errors = 0;
  int checks = 0;

  tlp_router #(
    .DATA_W   (DW),
    .NUM_DEST (ND)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .state           (state),
    .src_empty       (src_empty),
    .src_data        (src_data),
    .src_pop         (src_pop),
    .dst_almost_full (dst_almost_full),
    .dst_push        (dst_push),
    .dst_data        (dst_data),
    .stall           (stall),
    .dst_count       (dst_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] words [4];
  logic [19:0]   exp_burst_cnt;
  logic [19:0]   exp_wrap_cnt;
  int rd;
  int np;
  int last_cyc;

  initial begin
`ifdef TLP_ROUTER_STATS_EN
    exp_burst_cnt = 20'h08421;
    exp_wrap_cnt  = 20'h00400;
`else
    exp_burst_cnt = 20'h0;
    exp_wrap_cnt  = 20'h0;
`endif
    words[0] = 12'h000;
    words[1] = 12'h401;
    words[2] = 12'h802;
    words[3] = 12'hC03;

    reset           = 1'b0;
    state           = 4'b0100;
    src_empty       = 1'b1;
    src_data        = '0;
    dst_almost_full = '0;
    tick();
    tick();
    chk("rst_pop", 32'(src_pop), 0);
    chk("rst_push", 32'(dst_push), 0);
    chk("rst_data", 32'(dst_data), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_cnt", 32'(dst_count), 0);
    reset = 1'b1;
    tick();

    // single word
    src_empty = 1'b0;
    src_data  = 12'hC05;
    tick();
    chk("sw_pop", 32'(src_pop), 1);
    src_empty = 1'b1;
    tick();
    chk("sw_wait_pop", 32'(src_pop), 0);
    chk("sw_wait_push", 32'(dst_push), 0);
    tick();
    chk("sw_push", 32'(dst_push), 32'h8);
    chk("sw_data", 32'(dst_data), 32'hC05);
    tick();
    chk("sw_idle_push", 32'(dst_push), 0);
    chk("sw_idle_pop", 32'(src_pop), 0);
    chk("sw_hold_data", 32'(dst_data), 32'hC05);

    // backpressure
    dst_almost_full = 4'b0010;
    src_data        = 12'h4AA;
    src_empty       = 1'b0;
    tick();
    chk("bp_pop", 32'(src_pop), 1);
    tick();
    tick();
    chk("bp_route_push", 32'(dst_push), 0);
    tick();
    chk("bp_stall", 32'(stall), 1);
    chk("bp_stall_pop", 32'(src_pop), 0);
    tick();
    chk("bp_stall2", 32'(stall), 1);
    chk("bp_stall2_pop", 32'(src_pop), 0);
    chk("bp_stall2_push", 32'(dst_push), 0);
    dst_almost_full = 4'b0000;
    src_empty       = 1'b1;
    #1;
    chk("bp_push", 32'(dst_push), 32'h2);
    chk("bp_data", 32'(dst_data), 32'h4AA);
    tick();
    chk("bp_unstall", 32'(stall), 0);
    chk("bp_idle_pop", 32'(src_pop), 0);

    // synchronous clear
    state = 4'b0001;
    tick();
    chk("clr_data", 32'(dst_data), 0);
    chk("clr_cnt", 32'(dst_count), 0);
    state = 4'b0100;

    // burst of four words, one per destination
    rd        = 0;
    np        = 0;
    last_cyc  = 0;
    src_empty = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      if (dst_push != '0) begin
        if (np < 4) begin
          chk("burst_vec", 32'(dst_push), 32'(1) << np);
          chk("burst_data", 32'(dst_data), 32'(words[np]));
          if (np > 0) chk("burst_gap", 32'(cyc - last_cyc), 3);
        end
        last_cyc = cyc;
        np++;
      end
      if (src_pop) begin
        src_data  = words[rd];
        rd++;
        src_empty = (rd >= 4);
      end
    end
    chk("burst_npush", 32'(np), 4);
    chk("burst_cnt", 32'(dst_count), 32'(exp_burst_cnt));

    // reset during WAIT
    src_data  = 12'h8F0;
    src_empty = 1'b0;
    tick();
    chk("mr_pop", 32'(src_pop), 1);
    src_empty = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_pop0", 32'(src_pop), 0);
    chk("mr_push0", 32'(dst_push), 0);
    chk("mr_data0", 32'(dst_data), 0);
    chk("mr_stall0", 32'(stall), 0);
    chk("mr_cnt0", 32'(dst_count), 0);
    tick();
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("mr_idle_push", 32'(dst_push), 0);
      chk("mr_idle_pop", 32'(src_pop), 0);
    end

    // 33 pushes to destination 2
    src_data  = 12'h855;
    src_empty = 1'b0;
    np        = 0;
    for (int cyc = 0; cyc < 200 && np < 33; cyc++) begin
      tick();
      if (dst_push != '0) begin
        chk("wrap_vec", 32'(dst_push), 32'h4);
        np++;
        if (np == 33) src_empty = 1'b1;
      end
    end
    chk("wrap_npush", 32'(np), 33);
    tick();
    chk("wrap_cnt", 32'(dst_count), 32'(exp_wrap_cnt));

    // state gating
    state     = 4'b0010;
    src_data  = 12'hC05;
    src_empty = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("gate_init_pop", 32'(src_pop), 0);
    end
    state = 4'b0100;
    tick();
    chk("gate_act_pop", 32'(src_pop), 1);
    src_empty = 1'b1;
    tick();
    tick();
    chk("gate_push", 32'(dst_push), 32'h8);
    tick();
    chk("gate_done_pop", 32'(src_pop), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
